issue_entry_fifo: RTL

Small in-order buffer between the decode stage and the instruction reorder stage. Decoupled handshakes: decode is never stalled combinationally by issue. Presents the head entry and a one-deep lookahead (head+1), so the downstream reorder logic can see the next candidate before it pops the head. Flushed on mispredict or exception together with the rest of the frontend-to-issue path.

---
 rtl/issue_entry_fifo_pkg.sv | 16 +
 rtl/issue_entry_fifo_if.sv | 57 +++++
 rtl/issue_entry_fifo.sv | 89 ++++++++
 3 files changed

// File: rtl/issue_entry_fifo_pkg.sv
// Shared types for the decode-to-issue buffer.
// Entry layout is reused by the reorder stage delay slot.
package issue_entry_fifo_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [7:0]  op;
    logic [4:0]  rd;
  } scoreboard_entry_t;

  typedef struct packed {
    scoreboard_entry_t sbe;
    logic              is_ctrl_flow;
  } issue_fifo_entry_t;

endpackage

// File: rtl/issue_entry_fifo_if.sv
// Decode/issue handshake bundle for issue_entry_fifo.
// slave = the fifo, master = its environment.
interface issue_entry_fifo_if
  import issue_entry_fifo_pkg::*;
#(
  parameter int DEPTH = 4
) ();

  localparam int CW = $clog2(DEPTH) + 1;

  logic              flush_i;
  scoreboard_entry_t decoded_entry_i;
  logic              decoded_entry_valid_i;
  logic              is_ctrl_flow_i;
  logic              decoded_entry_ack_o;
  scoreboard_entry_t issue_entry_o;
  logic              issue_entry_valid_o;
  logic              is_ctrl_flow_o;
  logic              issue_instr_ack_i;
  scoreboard_entry_t next_entry_o;
  logic              next_entry_valid_o;
  logic              next_is_ctrl_flow_o;
  logic [CW-1:0]     count_o;

  modport slave (
    input  flush_i,
    input  decoded_entry_i,
    input  decoded_entry_valid_i,
    input  is_ctrl_flow_i,
    output decoded_entry_ack_o,
    output issue_entry_o,
    output issue_entry_valid_o,
    output is_ctrl_flow_o,
    input  issue_instr_ack_i,
    output next_entry_o,
    output next_entry_valid_o,
    output next_is_ctrl_flow_o,
    output count_o
  );

  modport master (
    output flush_i,
    output decoded_entry_i,
    output decoded_entry_valid_i,
    output is_ctrl_flow_i,
    input  decoded_entry_ack_o,
    input  issue_entry_o,
    input  issue_entry_valid_o,
    input  is_ctrl_flow_o,
    output issue_instr_ack_i,
    input  next_entry_o,
    input  next_entry_valid_o,
    input  next_is_ctrl_flow_o,
    input  count_o
  );

endinterface

// File: rtl/issue_entry_fifo.sv
// In-order decode-to-issue buffer with head and head+1 read ports.
// Flop storage; outputs are registered, no fall-through.
module issue_entry_fifo
  import issue_entry_fifo_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  issue_entry_fifo_if.slave  bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  issue_fifo_entry_t mem_q [DEPTH];
  issue_fifo_entry_t mem_d [DEPTH];
  logic [PW-1:0]     rd_q, rd_d;
  logic [PW-1:0]     wr_q, wr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     rd_nxt;
  logic              full;
  logic              push;
  logic              pop;

  assign full   = (cnt_q == CW'(DEPTH));
  assign rd_nxt = rd_q + PW'(1);

  // Ack ignores the pop on purpose: keeps issue off decode's path
  assign bus.decoded_entry_ack_o =
    bus.decoded_entry_valid_i & ~full;

  assign push = bus.decoded_entry_valid_i & ~full
              & ~bus.flush_i;
  assign pop  = bus.issue_instr_ack_i
              & bus.issue_entry_valid_o
              & ~bus.flush_i;

  assign bus.issue_entry_o       = mem_q[rd_q].sbe;
  assign bus.is_ctrl_flow_o      = mem_q[rd_q].is_ctrl_flow;
  assign bus.next_entry_o        = mem_q[rd_nxt].sbe;
  assign bus.next_is_ctrl_flow_o = mem_q[rd_nxt].is_ctrl_flow;
  assign bus.issue_entry_valid_o = (cnt_q >= CW'(1));
  assign bus.next_entry_valid_o  = (cnt_q >= CW'(2));
  assign bus.count_o             = cnt_q;

  always_comb begin
    mem_d = mem_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (bus.flush_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_q].sbe          = bus.decoded_entry_i;
        mem_d[wr_q].is_ctrl_flow = bus.is_ctrl_flow_i;
        wr_d = wr_q + PW'(1);
      end
      if (pop) begin
        rd_d = rd_nxt;
      end
      unique case ({push, pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule
